lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have: req_valid  input  1  pipeline presents a load/store.
REQ-005 SHALL have: req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have: req_funct3  input  3  RISC-V width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 SHALL have: req_addr  input  32  byte address, any alignment.
REQ-009 SHALL have: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have: rsp_rdata  output  32  extended load data; 0 for stores.
REQ-012 SHALL have: rsp_err  output  1  illegal funct3 flag, qualified by rsp_valid.
REQ-013 SHALL have: mem_req  output  1  memory transaction request.
REQ-014 SHALL have: mem_we  output  1  memory write.
REQ-015 SHALL have: mem_addr  output  32  word-aligned address (bits [1:0]=0).
REQ-016 SHALL have: mem_be  output  4  byte enables, lane i = bits [8i+7:8i].
REQ-017 SHALL have: mem_wdata  output  32  lane-aligned write data.
REQ-018 SHALL have: mem_ack  input  1  transaction complete; mem_rdata valid same cycle.
REQ-019 SHALL have: mem_rdata  input  32  little-endian read word.

Function
REQ-020 SHALL implement FSM IDLE, ACC0, ACC1, DONE; req_ready=1 only in IDLE.
REQ-021 IDLE: on req_valid SHALL latch we/funct3/addr/wdata and go to ACC0, or to DONE with error if funct3 is 011, 110 or 111.
REQ-022 Size mask SHALL be b/bu=0001, h/hu=0011, w=1111, shifted left by addr[1:0] into 8 bits; low nibble is the ACC0 be, high nibble is the ACC1 be.
REQ-023 Store data SHALL be shifted left by 8*addr[1:0] into 64 bits; low half drives ACC0, high half drives ACC1.
REQ-024 ACC0 SHALL drive mem_req=1, mem_addr={addr[31:2],2'b00}; on mem_ack it SHALL capture mem_rdata and go to ACC1 if the high nibble is nonzero, else DONE.
REQ-025 ACC1 SHALL drive mem_req=1, mem_addr=ACC0 address+4 (32-bit wrap at 0xFFFFFFFC); on mem_ack it SHALL capture mem_rdata and go to DONE.
REQ-026 mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be registered outputs and SHALL stay stable until the mem_ack cycle (any number of wait states).
REQ-027 Load result SHALL be {hi,lo} >> 8*addr[1:0], truncated to the access size, then sign-extended (b, h) or zero-extended (bu, hu).
REQ-028 DONE SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-029 Latency with zero-wait memory (ack in the request cycle): accepted at N, rsp_valid at N+2 for a single access and N+3 for a split access.
REQ-030 mem_ack outside ACC0/ACC1 SHALL be ignored; an error response SHALL produce no mem_req.

Reset
REQ-031 rst SHALL immediately force IDLE; req_ready=1, mem_req=0, mem_we=0, mem_be=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset during ACC0/ACC1 SHALL abandon the transaction; a late mem_ack SHALL be ignored.

Structure
REQ-033 Shared package lsu_pkg SHALL hold the funct3 constants and the FSM state enum.
REQ-034 Combinational lane shift and extension logic SHALL be the sub-module lsu_align.

Verification
REQ-035 Word@0x100=0x80FF1234; lb 0x103 -> rsp_rdata 0xFFFFFF80; lbu 0x103 -> 0x00000080; one mem_req each, mem_be=1000.
REQ-036 sh wdata=0x0000ABCD at 0x102 -> one access: mem_addr 0x100, mem_be 1100, mem_wdata 0xABCD0000, mem_we=1.
REQ-037 Word@0x0FC=0x44332211, word@0x100=0x88776655; lw 0x0FE -> be 1100 then 0011, rsp_rdata 0x66554433, rsp_valid at N+3.
REQ-038 funct3=011 -> no mem_req; rsp_valid with rsp_err=1 and rsp_rdata=0 at N+1.
REQ-039 mem_ack delayed 3 cycles on an aligned lw -> mem_* outputs stable throughout, rsp_valid at N+5.
REQ-040 rst pulse in ACC1 before mem_ack -> mem_req low in the same cycle, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 width codes for loads/stores
//   - FSM state encoding
//   - funct3 legality helper
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
//   funct3 : access width code
//   off    : byte offset within the word (addr[1:0])
//   wdata  : right-justified store data
//   lo, hi : read words from the first and second access (hi=0 if none)
//   be8    : size mask shifted by offset; [3:0] first access, [7:4] second
//   wd64   : store data shifted by 8*off; [31:0] first access, [63:32] second
//   ld     : load result, shifted down, truncated and extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] ld
);

    logic [3:0]  mask4;
    logic [4:0]  bit_sh;
    logic [31:0] rd;

    assign bit_sh = {off, 3'b000};

    // funct3[2] only selects signedness, so the size comes from bits [1:0]
    always_comb begin
        mask4 = 4'b0000;
        case (funct3[1:0])
            2'b00:   mask4 = 4'b0001;
            2'b01:   mask4 = 4'b0011;
            2'b10:   mask4 = 4'b1111;
            default: mask4 = 4'b0000;
        endcase
    end

    assign be8  = {4'b0000, mask4} << off;
    assign wd64 = {32'h0, wdata} << bit_sh;
    assign rd   = 32'({hi, lo} >> bit_sh);

    always_comb begin
        ld = 32'h0;
        case (funct3)
            F3_B:    ld = {{24{rd[7]}}, rd[7:0]};
            F3_H:    ld = {{16{rd[15]}}, rd[15:0]};
            F3_W:    ld = rd;
            F3_BU:   ld = {24'h0, rd[7:0]};
            F3_HU:   ld = {16'h0, rd[15:0]};
            default: ld = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit with misaligned access splitting.
//   Request side : req_valid/req_ready handshake, req_we, req_funct3,
//                  req_addr (any alignment), req_wdata (right-justified)
//   Response     : rsp_valid one-cycle pulse, rsp_rdata (0 for stores),
//                  rsp_err for illegal funct3
//   Memory side  : word-aligned mem_req/mem_we/mem_addr/mem_be/mem_wdata,
//                  all registered and held until mem_ack; mem_rdata is
//                  sampled in the mem_ack cycle.
// An access crossing a word boundary is issued as two word transactions
// (ACC0 at the base word, ACC1 at base+4).
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_e      state, state_nxt;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;

    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [31:0] al_lo, al_hi;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] ld;
    logic        legal;

    // In IDLE the aligner works on the live request so the first access
    // can be registered at accept; afterwards it works on latched fields.
    assign al_f3    = (state == ST_IDLE) ? req_funct3     : f3_q;
    assign al_off   = (state == ST_IDLE) ? req_addr[1:0]  : off_q;
    assign al_wdata = (state == ST_IDLE) ? req_wdata      : wdata_q;
    // Read data from the ack cycle is used directly, so the result is
    // ready on the same edge that enters DONE.
    assign al_lo    = (state == ST_ACC0) ? mem_rdata : lo_q;
    assign al_hi    = (state == ST_ACC1) ? mem_rdata : 32'h0;
    assign legal    = f3_legal(req_funct3);

    lsu_align u_align (
        .funct3 (al_f3),
        .off    (al_off),
        .wdata  (al_wdata),
        .lo     (al_lo),
        .hi     (al_hi),
        .be8    (be8),
        .wd64   (wd64),
        .ld     (ld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = legal ? ST_ACC0 : ST_DONE;
            end
            ST_ACC0: begin
                if (mem_ack) state_nxt = (be8[7:4] != 4'b0000) ? ST_ACC1 : ST_DONE;
            end
            ST_ACC1: begin
                if (mem_ack) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            wdata_q   <= 32'h0;
            lo_q      <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        rsp_err <= ~legal;
                        if (legal) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be8[3:0];
                            mem_wdata <= wd64[31:0];
                        end else begin
                            rsp_rdata <= 32'h0;
                        end
                    end
                end
                ST_ACC0: begin
                    if (mem_ack) begin
                        lo_q <= mem_rdata;
                        if (be8[7:4] != 4'b0000) begin
                            // Second word; mem_req and mem_we stay asserted
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= be8[7:4];
                            mem_wdata <= wd64[63:32];
                        end else begin
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_be    <= 4'b0000;
                            mem_wdata <= 32'h0;
                            rsp_rdata <= we_q ? 32'h0 : ld;
                        end
                    end
                end
                ST_ACC1: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                        rsp_rdata <= we_q ? 32'h0 : ld;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a word memory model, a response
// scoreboard (data, error flag, cycle of arrival) and an access log.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] words [0:255];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;

    assign mem_ack   = force_ack | (mem_req && (wait_cnt >= wait_cfg));
    assign mem_rdata = words[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) words[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    exp_t sb[$];
    acc_t acc_q[$];
    exp_t mon_e;
    acc_t mon_a;

    logic        pend = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            else begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        // memory outputs must hold through wait states
        if (mem_req && pend) begin
            chk("hold_addr", mem_addr, s_addr);
            chk("hold_be", 32'(mem_be), 32'(s_be));
            chk("hold_wdata", mem_wdata, s_wdata);
            chk("hold_we", 32'(mem_we), 32'(s_we));
        end
        if (mem_req && mem_ack) begin
            mon_a.addr = mem_addr; mon_a.be = mem_be;
            mon_a.wdata = mem_wdata; mon_a.we = mem_we;
            acc_q.push_back(mon_a);
        end
        pend    = mem_req && !mem_ack;
        s_addr  = mem_addr; s_be = mem_be; s_wdata = mem_wdata; s_we = mem_we;
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] erd,
                          input logic eerr, input int lat);
        exp_t e;
        int   i;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'h1);
        e.rdata = erd; e.err = eerr; e.cyc = cyc + lat;
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        i = 0;
        while (sb.size() != 0 && i < 30) begin
            @(negedge clk); #1; i++;
        end
        chk("rsp_timeout", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic chk_acc(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic we);
        acc_t x;
        if (acc_q.size() == 0) chk({tag, "_missing"}, 32'(acc_q.size()), 32'h1);
        else begin
            x = acc_q.pop_front();
            chk({tag, "_addr"}, x.addr, a);
            chk({tag, "_be"}, 32'(x.be), 32'(be));
            chk({tag, "_wdata"}, x.wdata, wd);
            chk({tag, "_we"}, 32'(x.we), 32'(we));
        end
    endtask

    task automatic chk_no_acc(input string tag);
        chk(tag, 32'(acc_q.size()), 32'h0);
        acc_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int i;
        for (int k = 0; k < 256; k++) words[k] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); rst = 1'b0;

        // byte/half/word loads from one word
        words[8'h40] = 32'h80FF1234;
        do_req(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        chk_acc("lb", 32'h100, 4'b1000, 32'h0, 1'b0);
        chk_no_acc("lb_one_access");
        do_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 2);
        chk_acc("lbu", 32'h100, 4'b1000, 32'h0, 1'b0);
        chk_no_acc("lbu_one_access");
        do_req(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80FF, 1'b0, 2);
        chk_acc("lh", 32'h100, 4'b1100, 32'h0, 1'b0);
        do_req(1'b0, 3'b101, 32'h100, 32'h0, 32'h00001234, 1'b0, 2);
        chk_acc("lhu", 32'h100, 4'b0011, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF1234, 1'b0, 2);
        chk_acc("lw", 32'h100, 4'b1111, 32'h0, 1'b0);

        // halfword store, then read back
        do_req(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1'b0, 2);
        chk_acc("sh", 32'h100, 4'b1100, 32'hABCD0000, 1'b1);
        chk_no_acc("sh_one_access");
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hABCD1234, 1'b0, 2);
        chk_acc("lw_after_sh", 32'h100, 4'b1111, 32'h0, 1'b0);

        // split word load across 0x0FC/0x100
        words[8'h3F] = 32'h44332211;
        words[8'h40] = 32'h88776655;
        do_req(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h66554433, 1'b0, 3);
        chk_acc("lw_split0", 32'h0FC, 4'b1100, 32'h0, 1'b0);
        chk_acc("lw_split1", 32'h100, 4'b0011, 32'h0, 1'b0);

        // split word store, then read both words back
        do_req(1'b1, 3'b010, 32'h0FD, 32'hDDCCBBAA, 32'h0, 1'b0, 3);
        chk_acc("sw_split0", 32'h0FC, 4'b1110, 32'hCCBBAA00, 1'b1);
        chk_acc("sw_split1", 32'h100, 4'b0001, 32'h000000DD, 1'b1);
        do_req(1'b0, 3'b010, 32'h0FC, 32'h0, 32'hCCBBAA11, 1'b0, 2);
        do_req(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFDD, 1'b0, 2);
        do_req(1'b0, 3'b100, 32'h100, 32'h0, 32'h000000DD, 1'b0, 2);
        acc_q.delete();

        // halfword at the top of the address space wraps to word 0
        words[8'hFF] = 32'h5A000000;
        words[8'h00] = 32'h00000081;
        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFF815A, 1'b0, 3);
        chk_acc("wrap0", 32'hFFFFFFFC, 4'b1000, 32'h0, 1'b0);
        chk_acc("wrap1", 32'h00000000, 4'b0001, 32'h0, 1'b0);

        // illegal funct3: error, no memory traffic
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        chk_no_acc("err011_no_access");
        do_req(1'b1, 3'b111, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
        chk_no_acc("err111_no_access");

        // three wait states on an aligned load
        wait_cfg = 3;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h887766DD, 1'b0, 5);
        chk_acc("lw_wait", 32'h100, 4'b1111, 32'h0, 1'b0);
        wait_cfg = 0;

        // stray acks in IDLE are ignored
        @(negedge clk); force_ack = 1'b1;
        @(negedge clk); #1;
        chk("stray_ack_ready", 32'(req_ready), 32'h1);
        chk("stray_ack_rsp", 32'(rsp_valid), 32'h0);
        force_ack = 1'b0;

        // reset while waiting in ACC1
        wait_cfg = 5;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0FE; req_wdata = 32'h0;
        @(negedge clk); req_valid = 1'b0;
        i = 0;
        while (!(mem_req && mem_be == 4'b0011) && i < 20) begin
            @(negedge clk); i++;
        end
        chk("reached_acc1", 32'(mem_be), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_acc1_mem_req", 32'(mem_req), 32'h0);
        chk("rst_acc1_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_acc1_ready", 32'(req_ready), 32'h1);
        @(negedge clk); rst = 1'b0; force_ack = 1'b1; wait_cfg = 0;
        @(negedge clk); force_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_mem_req", 32'(mem_req), 32'h0);
        acc_q.delete();

        // unit works normally after the abandoned transaction
        do_req(1'b0, 3'b101, 32'h0FE, 32'h0, 32'h0000CCBB, 1'b0, 2);
        chk_acc("post_rst_lhu", 32'h0FC, 4'b1100, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
